// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the SRAM-port-to-unified-memory bridge.
// Used by sram_bridge and its optional fetch buffer sram_bridge_ibuf.
package sram_bridge_pkg;

  localparam int BRG_STATE_WD = 3;
  localparam int ADDR_WD      = 32;
  localparam int DATA_WD      = 32;
  localparam int STRB_WD      = 4;
  localparam int WORD_WD      = ADDR_WD - 2;

  typedef enum logic [BRG_STATE_WD-1:0] {
    BRG_IDLE  = 3'd0,
    BRG_DREQ  = 3'd1,
    BRG_DWAIT = 3'd2,
    BRG_IREQ  = 3'd3,
    BRG_IWAIT = 3'd4,
    BRG_DONE  = 3'd5
  } brg_state_e;

  // Rebuild a byte address from a word index; the memory side only ever sees aligned addresses.
  function automatic logic [ADDR_WD-1:0] word_to_addr(input logic [WORD_WD-1:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/sram_bridge_ibuf.sv
// Single-entry fetch buffer (valid, word tag, word) for sram_bridge.
// Refilled on every fetch completion, invalidated by a store to the tagged word.
module sram_bridge_ibuf
  import sram_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_WD-1:0] lookup_word,
  output logic               hit,
  output logic [DATA_WD-1:0] hit_data,
  input  logic               fill_en,
  input  logic [WORD_WD-1:0] fill_word,
  input  logic [DATA_WD-1:0] fill_data,
  input  logic               inv_en,
  input  logic [WORD_WD-1:0] inv_word
);

  logic               valid_q, valid_d;
  logic [WORD_WD-1:0] tag_q, tag_d;
  logic [DATA_WD-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_word;
      data_d  = fill_data;
    end else if (inv_en && valid_q && (inv_word == tag_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_word);
  assign hit_data = data_q;

endmodule

// File: rtl/sram_bridge.sv
// Serves the core's fetch and load/store SRAM ports from one addr_ok/data_ok memory port,
// data first, stalling the pipeline until done. SRAM_BRIDGE_IBUF_EN adds a one-word fetch buffer.
module sram_bridge
  import sram_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_sram_en,
  input  logic [STRB_WD-1:0] inst_sram_wen,
  input  logic [ADDR_WD-1:0] inst_sram_addr,
  input  logic [DATA_WD-1:0] inst_sram_wdata,
  output logic [DATA_WD-1:0] inst_sram_rdata,
  input  logic               data_sram_en,
  input  logic [STRB_WD-1:0] data_sram_wen,
  input  logic [ADDR_WD-1:0] data_sram_addr,
  input  logic [DATA_WD-1:0] data_sram_wdata,
  output logic [DATA_WD-1:0] data_sram_rdata,
  output logic               stallreq_for_bus,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [STRB_WD-1:0] mem_wstrb,
  output logic [ADDR_WD-1:0] mem_addr,
  output logic [DATA_WD-1:0] mem_wdata,
  input  logic               mem_addr_ok,
  input  logic               mem_data_ok,
  input  logic [DATA_WD-1:0] mem_rdata
);

  brg_state_e         state_q, state_d;
  logic               d_pend_q, d_pend_d;
  logic [STRB_WD-1:0] d_wen_q, d_wen_d;
  logic [WORD_WD-1:0] d_word_q, d_word_d;
  logic [DATA_WD-1:0] d_wdata_q, d_wdata_d;
  logic               i_pend_q, i_pend_d;
  logic [WORD_WD-1:0] i_word_q, i_word_d;
  logic [DATA_WD-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_WD-1:0] data_rdata_q, data_rdata_d;

  logic               ibuf_hit;
  logic [DATA_WD-1:0] ibuf_data;

  // Fetch write port/strobe and sub-word address bits carry no meaning for a word-wide bus.
  logic unused_ok;
  assign unused_ok = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[1:0],
                       data_sram_addr[1:0], d_pend_q};

`ifdef SRAM_BRIDGE_IBUF_EN
  logic ibuf_fill;
  logic ibuf_inv;

  assign ibuf_fill = (state_q == BRG_IWAIT) && mem_data_ok;
  assign ibuf_inv  = (state_q == BRG_DWAIT) && mem_data_ok && (d_wen_q != '0);

  sram_bridge_ibuf u_ibuf (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (inst_sram_addr[ADDR_WD-1:2]),
    .hit         (ibuf_hit),
    .hit_data    (ibuf_data),
    .fill_en     (ibuf_fill),
    .fill_word   (i_word_q),
    .fill_data   (mem_rdata),
    .inv_en      (ibuf_inv),
    .inv_word    (d_word_q)
  );
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  always_comb begin
    state_d          = state_q;
    d_pend_d         = d_pend_q;
    d_wen_d          = d_wen_q;
    d_word_d         = d_word_q;
    d_wdata_d        = d_wdata_q;
    i_pend_d         = i_pend_q;
    i_word_d         = i_word_q;
    inst_rdata_d     = inst_rdata_q;
    data_rdata_d     = data_rdata_q;
    stallreq_for_bus = 1'b0;
    mem_req          = 1'b0;
    mem_wr           = 1'b0;
    mem_wstrb        = '0;
    mem_addr         = '0;
    mem_wdata        = '0;

    case (state_q)
      BRG_IDLE: begin
        d_pend_d  = data_sram_en;
        d_wen_d   = data_sram_wen;
        d_word_d  = data_sram_addr[ADDR_WD-1:2];
        d_wdata_d = data_sram_wdata;
        i_pend_d  = inst_sram_en;
        i_word_d  = inst_sram_addr[ADDR_WD-1:2];
        if (data_sram_en) begin
          state_d = BRG_DREQ;
        end else if (inst_sram_en) begin
          if (ibuf_hit) begin
            // Buffered fetch completes without touching memory or stalling.
            state_d      = BRG_DONE;
            i_pend_d     = 1'b0;
            inst_rdata_d = ibuf_data;
          end else begin
            state_d = BRG_IREQ;
          end
        end
      end

      BRG_DREQ: begin
        stallreq_for_bus = 1'b1;
        mem_req          = 1'b1;
        mem_wr           = (d_wen_q != '0);
        mem_wstrb        = d_wen_q;
        mem_addr         = word_to_addr(d_word_q);
        mem_wdata        = d_wdata_q;
        if (mem_addr_ok) begin
          state_d = BRG_DWAIT;
        end
      end

      BRG_DWAIT: begin
        stallreq_for_bus = 1'b1;
        if (mem_data_ok) begin
          if (d_wen_q == '0) begin
            data_rdata_d = mem_rdata;
          end
          state_d = i_pend_q ? BRG_IREQ : BRG_DONE;
        end
      end

      BRG_IREQ: begin
        stallreq_for_bus = 1'b1;
        mem_req          = 1'b1;
        mem_addr         = word_to_addr(i_word_q);
        if (mem_addr_ok) begin
          state_d = BRG_IWAIT;
        end
      end

      BRG_IWAIT: begin
        stallreq_for_bus = 1'b1;
        if (mem_data_ok) begin
          inst_rdata_d = mem_rdata;
          state_d      = BRG_DONE;
        end
      end

      BRG_DONE: begin
        state_d = BRG_IDLE;
      end

      default: begin
        state_d = BRG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BRG_IDLE;
      d_pend_q     <= 1'b0;
      d_wen_q      <= '0;
      d_word_q     <= '0;
      d_wdata_q    <= '0;
      i_pend_q     <= 1'b0;
      i_word_q     <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      d_pend_q     <= d_pend_d;
      d_wen_q      <= d_wen_d;
      d_word_q     <= d_word_d;
      d_wdata_q    <= d_wdata_d;
      i_pend_q     <= i_pend_d;
      i_word_q     <= i_word_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed self-checking bench for sram_bridge; the fetch-buffer scenario follows SRAM_BRIDGE_IBUF_EN.
module tb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_bus;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int fails  = 0;
  int stall_cnt = 0;

  sram_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_wen    (inst_sram_wen),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_rdata  (inst_sram_rdata),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata),
    .stallreq_for_bus (stallreq_for_bus),
    .mem_req          (mem_req),
    .mem_wr           (mem_wr),
    .mem_wstrb        (mem_wstrb),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_addr_ok      (mem_addr_ok),
    .mem_data_ok      (mem_data_ok),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stallreq_for_bus) stall_cnt <= stall_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the memory side for one request: waits (bounded) for mem_req, records what it saw,
  // accepts it immediately, and returns rdata one cycle later. Does no checking itself.
  task automatic mem_serve(input logic [31:0] rdata, output logic [31:0] o_addr,
                           output logic o_wr, output logic [3:0] o_strb,
                           output logic [31:0] o_wdata, output bit o_seen);
    o_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) begin
        o_seen = 1'b1;
        break;
      end
      tick();
    end
    o_addr  = mem_addr;
    o_wr    = mem_wr;
    o_strb  = mem_wstrb;
    o_wdata = mem_wdata;
    if (o_seen) begin
      mem_addr_ok = 1'b1;
      tick();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      mem_rdata   = rdata;
      tick();
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (stallreq_for_bus !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b want=0", stallreq_for_bus); end
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b want=0", mem_req); end
    checks++; if ({mem_wr, mem_wstrb, mem_addr, mem_wdata} !== 69'h0) begin fails++; $display("FAIL reset_membus wr=%b strb=%h addr=%h wdata=%h want all 0", mem_wr, mem_wstrb, mem_addr, mem_wdata); end
    checks++; if ({inst_sram_rdata, data_sram_rdata} !== 64'h0) begin fails++; $display("FAIL reset_rdata inst=%h data=%h want 0", inst_sram_rdata, data_sram_rdata); end
    rst = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_fetch(input logic [31:0] addr, input logic [31:0] word, input string tag);
    logic [31:0] a, wd;
    logic w;
    logic [3:0] s;
    bit seen;
    int s0;
    s0 = stall_cnt;
    inst_sram_en   = 1'b1;
    inst_sram_addr = addr;
    tick();
    inst_sram_en = 1'b0;
    mem_serve(word, a, w, s, wd, seen);
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL %s_req_timeout got=%b want=1", tag, seen); end
    checks++; if (a !== addr) begin fails++; $display("FAIL %s_addr got=%h want=%h", tag, a, addr); end
    checks++; if (w !== 1'b0) begin fails++; $display("FAIL %s_wr got=%b want=0", tag, w); end
    checks++; if (stallreq_for_bus !== 1'b0) begin fails++; $display("FAIL %s_done_stall got=%b want=0", tag, stallreq_for_bus); end
    checks++; if (inst_sram_rdata !== word) begin fails++; $display("FAIL %s_rdata got=%h want=%h", tag, inst_sram_rdata, word); end
    tick();
    checks++; if (stall_cnt - s0 != 2) begin fails++; $display("FAIL %s_stall_cycles got=%0d want=2", tag, stall_cnt - s0); end
    $display("%s: addr=%h rdata=%h", tag, addr, inst_sram_rdata);
  endtask

  task automatic test_load_fetch();
    logic [31:0] a1, a2, wd;
    logic w1, w2;
    logic [3:0] s;
    bit seen1, seen2;
    int s0;
    s0 = stall_cnt;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h80000010;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC00008;
    tick();
    data_sram_en = 1'b0;
    inst_sram_en = 1'b0;
    mem_serve(32'h12345678, a1, w1, s, wd, seen1);
    mem_serve(32'h8C080000, a2, w2, s, wd, seen2);
    checks++; if ({seen1, seen2} !== 2'b11) begin fails++; $display("FAIL lf_req_timeout got=%b want=11", {seen1, seen2}); end
    checks++; if (a1 !== 32'h80000010 || w1 !== 1'b0) begin fails++; $display("FAIL lf_first_req addr=%h wr=%b want 80000010/0", a1, w1); end
    checks++; if (a2 !== 32'hBFC00008 || w2 !== 1'b0) begin fails++; $display("FAIL lf_second_req addr=%h wr=%b want bfc00008/0", a2, w2); end
    checks++; if (data_sram_rdata !== 32'h12345678) begin fails++; $display("FAIL lf_data_rdata got=%h want=12345678", data_sram_rdata); end
    checks++; if (inst_sram_rdata !== 32'h8C080000) begin fails++; $display("FAIL lf_inst_rdata got=%h want=8c080000", inst_sram_rdata); end
    tick();
    checks++; if (stall_cnt - s0 != 4) begin fails++; $display("FAIL lf_stall_cycles got=%0d want=4", stall_cnt - s0); end
    $display("load+fetch: data=%h inst=%h", data_sram_rdata, inst_sram_rdata);
  endtask

  task automatic test_store(input logic [31:0] addr, input logic [3:0] wen,
                            input logic [31:0] wdata, input logic [31:0] prev_rdata);
    logic [31:0] a, wd, exp_addr;
    logic w;
    logic [3:0] s;
    bit seen;
    int s0;
    exp_addr = {addr[31:2], 2'b00};
    s0 = stall_cnt;
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    tick();
    data_sram_en = 1'b0;
    mem_serve(32'hDEADBEEF, a, w, s, wd, seen);
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL st_req_timeout got=%b want=1", seen); end
    checks++; if (a !== exp_addr) begin fails++; $display("FAIL st_addr got=%h want=%h", a, exp_addr); end
    checks++; if (w !== 1'b1 || s !== wen) begin fails++; $display("FAIL st_wr_strb wr=%b strb=%b want 1/%b", w, s, wen); end
    checks++; if (wd !== wdata) begin fails++; $display("FAIL st_wdata got=%h want=%h", wd, wdata); end
    checks++; if (data_sram_rdata !== prev_rdata) begin fails++; $display("FAIL st_rdata_kept got=%h want=%h", data_sram_rdata, prev_rdata); end
    tick();
    checks++; if (stall_cnt - s0 != 2) begin fails++; $display("FAIL st_stall_cycles got=%0d want=2", stall_cnt - s0); end
    $display("store: addr=%h strb=%b wdata=%h", a, s, wd);
  endtask

  task automatic test_backpressure();
    int s0;
    s0 = stall_cnt;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h80000040;
    data_sram_wdata = 32'h0;
    tick();
    data_sram_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_data_ok = (i == 2);
      mem_rdata   = (i == 2) ? 32'hBAD0BAD0 : 32'h0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h80000040 || mem_wdata !== 32'h0 || stallreq_for_bus !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold_%0d req=%b addr=%h wdata=%h stall=%b want 1/80000040/0/1", i, mem_req, mem_addr, mem_wdata, stallreq_for_bus);
      end
      tick();
    end
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h5A5A1234;
    tick();
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    checks++; if (data_sram_rdata !== 32'h5A5A1234) begin fails++; $display("FAIL bp_rdata got=%h want=5a5a1234", data_sram_rdata); end
    tick();
    checks++; if (stall_cnt - s0 != 7) begin fails++; $display("FAIL bp_stall_cycles got=%0d want=7", stall_cnt - s0); end
    $display("backpressure: rdata=%h", data_sram_rdata);
  endtask

  task automatic test_reset_mid();
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h80000050;
    tick();
    data_sram_en = 1'b0;
    mem_addr_ok  = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    checks++; if (stallreq_for_bus !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL rm_in_dwait stall=%b req=%b want 1/0", stallreq_for_bus, mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0 || stallreq_for_bus !== 1'b0) begin fails++; $display("FAIL rm_idle req=%b stall=%b want 0/0", mem_req, stallreq_for_bus); end
    checks++; if ({inst_sram_rdata, data_sram_rdata} !== 64'h0) begin fails++; $display("FAIL rm_rdata inst=%h data=%h want 0", inst_sram_rdata, data_sram_rdata); end
    tick();
    checks++; if (mem_req !== 1'b0 || stallreq_for_bus !== 1'b0) begin fails++; $display("FAIL rm_stays_idle req=%b stall=%b want 0/0", mem_req, stallreq_for_bus); end
    $display("reset mid-transaction: idle");
  endtask

  task automatic test_repeat_fetch();
    test_fetch(32'hBFC00004, 32'h24080001, "ibuf_first");
`ifdef SRAM_BRIDGE_IBUF_EN
    begin
      int s0;
      s0 = stall_cnt;
      inst_sram_en   = 1'b1;
      inst_sram_addr = 32'hBFC00004;
      tick();
      inst_sram_en = 1'b0;
      checks++; if (mem_req !== 1'b0 || stallreq_for_bus !== 1'b0) begin fails++; $display("FAIL ibuf_hit req=%b stall=%b want 0/0", mem_req, stallreq_for_bus); end
      checks++; if (inst_sram_rdata !== 32'h24080001) begin fails++; $display("FAIL ibuf_hit_rdata got=%h want=24080001", inst_sram_rdata); end
      tick();
      checks++; if (stall_cnt - s0 != 0) begin fails++; $display("FAIL ibuf_hit_stall got=%0d want=0", stall_cnt - s0); end
      $display("ibuf hit: rdata=%h", inst_sram_rdata);
    end
`else
    test_fetch(32'hBFC00004, 32'h24080001, "refetch");
`endif
    test_store(32'hBFC00004, 4'b1111, 32'h11112222, data_sram_rdata);
    test_fetch(32'hBFC00004, 32'h11112222, "fetch_after_store");
  endtask

  initial begin
    rst             = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'b0000;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    mem_addr_ok     = 1'b0;
    mem_data_ok     = 1'b0;
    mem_rdata       = 32'h0;

    test_reset();
    test_fetch(32'hBFC00004, 32'h24080001, "fetch");
    test_load_fetch();
    test_store(32'h80000022, 4'b0011, 32'hAABBCCDD, 32'h12345678);
    test_backpressure();
    test_reset_mid();
    test_repeat_fetch();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Responder for the core's two SRAM-style ports (instruction and data). It serves fetch and load/store requests from a single unified memory port that uses an addr_ok/data_ok handshake. Until each response is ready, it holds the pipeline through a stall request. It sits between `mycpu_core` and the memory/AXI side at the top level; its `stallreq_for_bus` output feeds CTRL as a third stall source.

## Interface
Parameters:
- none (widths fixed at 32-bit address/data, 4-bit byte strobe)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- inst_sram_en  in  1  fetch request valid
- inst_sram_wen  in  4  ignored (fetch is read-only)
- inst_sram_addr  in  32  fetch byte address
- inst_sram_wdata  in  32  ignored
- inst_sram_rdata  out  32  fetched word, valid in DONE
- data_sram_en  in  1  load/store request valid
- data_sram_wen  in  4  byte strobe; 0 = read
- data_sram_addr  in  32  data byte address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  load word, valid in DONE
- stallreq_for_bus  out  1  freeze pipeline
- mem_req  out  1  memory request valid
- mem_wr  out  1  1 = write
- mem_wstrb  out  4  write byte strobe
- mem_addr  out  32  word-aligned address (low 2 bits forced 0)
- mem_wdata  out  32  write data
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  response (read data or write ack) this cycle
- mem_rdata  in  32  read data, valid with mem_data_ok

## Operation
- States: IDLE, DREQ, DWAIT, IREQ, IWAIT, DONE.
- IDLE:
  - Samples the core requests into capture registers at the clock edge.
  - If data_sram_en, go to DREQ, else if inst_sram_en, go to IREQ, else stay.
  - The data request always has priority. When both are enabled, both are latched and the data request is served first.
- DREQ:
  - mem_req=1, mem_wr=(wen!=0), mem_wstrb=wen, mem_addr/wdata from capture.
  - On mem_addr_ok, go to DWAIT.
- DWAIT:
  - On mem_data_ok: reads latch mem_rdata into data_sram_rdata; writes discard mem_rdata.
  - Then go to IREQ if a fetch is latched, else to DONE.
- IREQ/IWAIT: same as DREQ/DWAIT, read only; on mem_data_ok, latch into inst_sram_rdata and go to DONE.
- DONE:
  - Always goes to IDLE next cycle.
  - Requests presented in DONE are not sampled; they are the ones just served.
- stallreq_for_bus = 1 in DREQ, DWAIT, IREQ, IWAIT; 0 in IDLE and DONE.
- mem_req held until accepted; address, data and strobe stable while mem_req=1 and not accepted.
- A mem_data_ok outside DWAIT/IWAIT is ignored.
- rdata registers hold their last value until overwritten.

## Timing
- Reset values:
  - state=IDLE, stallreq_for_bus=0, mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - inst_sram_rdata=0, data_sram_rdata=0, capture registers cleared.
- Reset mid-transaction:
  - Returns to IDLE next cycle and drops mem_req.
  - The memory side shares rst, so no stale response is expected after reset.
- Best-case single read:
  - Request sampled at edge T, giving DREQ/IREQ in T+1.
  - addr_ok in T+1 and data_ok in T+2 give DONE in T+3.
  - stall is high for T+1 to T+2 (2 cycles).
- Combined data+fetch, best case: stall high for 4 cycles; DONE in T+5 with both rdata valid.
- Write: same timing as a read; DONE is reached only after the write ack (data_ok).

## Configuration
- `SRAM_BRIDGE_IBUF_EN` defined: single-entry fetch buffer (valid, word tag, word).
  - In IDLE, a fetch hit (valid and tag==addr[31:2]) with no data request goes directly to DONE, with zero stall cycles and rdata taken from the buffer.
  - Every IWAIT completion refills the buffer.
  - A data write whose word address equals the tag clears valid.
  - rst clears valid.
- Not defined: every fetch goes to memory; no buffer logic present.

## Structure
- State encodings (`BRG_IDLE` … `BRG_DONE`, 3-bit) and `BRG_STATE_WD` go in lib/defines.vh beside the existing bus widths.
- Sub-module `sram_bridge_ibuf` holds the fetch buffer and is instantiated only under `SRAM_BRIDGE_IBUF_EN`.
- Top-level change: CTRL gains the `stallreq_for_bus` input, ORed into the stall vector.

## Test plan
- Fetch only:
  - Stimulus: inst addr 0xBFC00004, addr_ok immediate, data_ok next cycle with 0x24080001.
  - Response: stall 2 cycles, inst_sram_rdata=0x24080001 in DONE, mem_addr=0xBFC00004, mem_wr=0.
- Load + fetch same cycle:
  - Stimulus: data read addr 0x80000010 (returns 0x12345678) and fetch 0xBFC00008 (returns 0x8C080000).
  - Response: data is issued first, stall 4 cycles, both rdata correct in DONE.
- Store:
  - Stimulus: wen=4'b0011, addr 0x80000022, wdata 0xAABBCCDD.
  - Response: mem_addr=0x80000020, mem_wstrb=4'b0011, mem_wr=1; DONE after ack; data_sram_rdata unchanged.
- Backpressure:
  - Stimulus: addr_ok held low 5 cycles.
  - Response: mem_req, mem_addr and mem_wdata stable throughout; stall stays high; mem_data_ok pulsed while in DREQ is ignored.
- Reset mid-transaction:
  - Stimulus: rst pulsed in DWAIT.
  - Response: next cycle state=IDLE, mem_req=0, stall=0, rdata outputs=0.
- With `SRAM_BRIDGE_IBUF_EN`:
  - Stimulus: repeat fetch of 0xBFC00004.
  - Response: second fetch has zero stall and no mem_req.
  - Then a store to 0xBFC00004 followed by a fetch of it: mem_req is issued again.
